// File: rtl/instruction_fetch.sv
// Instruction fetch: PC generation, in-order I-cache request tracking and a small
// instruction buffer for decode, with redirect handling and stale-response dropping.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fetch_en,
  input  logic        i_br_valid,
  input  logic [31:0] i_br_addr,
  output logic        o_icache_req,
  output logic [31:0] o_icache_addr,
  input  logic        i_icache_ready,
  input  logic        i_icache_rvalid,
  input  logic [31:0] i_icache_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pcplus4
);
  localparam int unsigned   PW        = $clog2(BUF_DEPTH);
  localparam int unsigned   CW        = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] ZERO_C    = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C     = CW'(1'b1);
  localparam logic [PW-1:0] PTR_ZERO_C = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE_C  = PW'(1'b1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
  logic [PW-1:0] pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
  logic [31:0]   buf_instr_q [BUF_DEPTH];
  logic [31:0]   buf_pc_q    [BUF_DEPTH];
  logic [31:0]   pq_pc_q     [BUF_DEPTH];

  logic [CW:0]   inflight_s;
  logic          req_s, accept_s, resp_s, keep_s, valid_s, pop_s;
  logic [31:0]   head_pc_s;
  logic          unused_s;

  // Outstanding requests plus buffered entries bound the buffer occupancy.
  assign inflight_s = {1'b0, out_q} + {1'b0, cnt_q};
  assign req_s      = ~rst & i_fetch_en & ~i_br_valid & (inflight_s < {1'b0, DEPTH_C});
  assign accept_s   = req_s & i_icache_ready;
  assign resp_s     = i_icache_rvalid & (out_q != ZERO_C);
  assign keep_s     = resp_s & ~rst & ~i_br_valid & (drop_q == ZERO_C);
  assign valid_s    = ~rst & (cnt_q != ZERO_C);
  assign pop_s      = valid_s & i_fetch_en & ~i_br_valid;
  assign head_pc_s  = buf_pc_q[buf_rd_q];
  assign unused_s   = ^i_br_addr[1:0];

  assign o_icache_req  = req_s;
  assign o_icache_addr = fetch_pc_q;
  assign o_instr_valid = valid_s;
  assign o_instr       = valid_s ? buf_instr_q[buf_rd_q] : 32'h0000_0000;
  assign o_pc          = valid_s ? head_pc_s : 32'h0000_0000;
  assign o_pcplus4     = valid_s ? head_pc_s + 32'd4 : 32'h0000_0000;

  // Next-state for PC, counters and pointers; reset beats redirect beats normal flow.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    cnt_d      = cnt_q;
    buf_wr_d   = buf_wr_q;
    buf_rd_d   = buf_rd_q;
    pq_wr_d    = pq_wr_q;
    pq_rd_d    = pq_rd_q;
    if (rst) begin
      fetch_pc_d = {RESET_PC[31:2], 2'b00};
      out_d      = ZERO_C;
      drop_d     = ZERO_C;
      cnt_d      = ZERO_C;
      buf_wr_d   = PTR_ZERO_C;
      buf_rd_d   = PTR_ZERO_C;
      pq_wr_d    = PTR_ZERO_C;
      pq_rd_d    = PTR_ZERO_C;
    end else if (i_br_valid) begin
      // Every request still in flight becomes stale, minus one returning right now.
      fetch_pc_d = {i_br_addr[31:2], 2'b00};
      out_d      = out_q - CW'(resp_s);
      drop_d     = out_q - CW'(resp_s);
      cnt_d      = ZERO_C;
      buf_wr_d   = PTR_ZERO_C;
      buf_rd_d   = PTR_ZERO_C;
      pq_wr_d    = PTR_ZERO_C;
      pq_rd_d    = PTR_ZERO_C;
    end else begin
      fetch_pc_d = accept_s ? fetch_pc_q + 32'd4 : fetch_pc_q;
      pq_wr_d    = accept_s ? pq_wr_q + PTR_ONE_C : pq_wr_q;
      pq_rd_d    = keep_s ? pq_rd_q + PTR_ONE_C : pq_rd_q;
      buf_wr_d   = keep_s ? buf_wr_q + PTR_ONE_C : buf_wr_q;
      buf_rd_d   = pop_s ? buf_rd_q + PTR_ONE_C : buf_rd_q;
      out_d      = out_q + CW'(accept_s) - CW'(resp_s);
      drop_d     = (resp_s && (drop_q != ZERO_C)) ? drop_q - ONE_C : drop_q;
      cnt_d      = cnt_q + CW'(keep_s) - CW'(pop_s);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      out_q      <= ZERO_C;
      drop_q     <= ZERO_C;
      cnt_q      <= ZERO_C;
      buf_wr_q   <= PTR_ZERO_C;
      buf_rd_q   <= PTR_ZERO_C;
      pq_wr_q    <= PTR_ZERO_C;
      pq_rd_q    <= PTR_ZERO_C;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      buf_wr_q   <= buf_wr_d;
      buf_rd_q   <= buf_rd_d;
      pq_wr_q    <= pq_wr_d;
      pq_rd_q    <= pq_rd_d;
    end
  end

  // Storage arrays; occupancy is tracked by the counters, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      pq_pc_q[pq_wr_q] <= fetch_pc_q;
    end
    if (keep_s) begin
      buf_instr_q[buf_wr_q] <= i_icache_rdata;
      buf_pc_q[buf_wr_q]    <= pq_pc_q[pq_rd_q];
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by random
// traffic, all compared every cycle against a queue-based reference model.
module tb_instruction_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_fetch_en = 1'b0;
  logic        i_br_valid = 1'b0;
  logic [31:0] i_br_addr = 32'h0;
  logic        o_icache_req;
  logic [31:0] o_icache_addr;
  logic        i_icache_ready = 1'b0;
  logic        i_icache_rvalid = 1'b0;
  logic [31:0] i_icache_rdata = 32'h0;
  logic        o_instr_valid;
  logic [31:0] o_instr, o_pc, o_pcplus4;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_fetch_en(i_fetch_en), .i_br_valid(i_br_valid),
    .i_br_addr(i_br_addr), .o_icache_req(o_icache_req), .o_icache_addr(o_icache_addr),
    .i_icache_ready(i_icache_ready), .i_icache_rvalid(i_icache_rvalid),
    .i_icache_rdata(i_icache_rdata), .o_instr_valid(o_instr_valid), .o_instr(o_instr),
    .o_pc(o_pc), .o_pcplus4(o_pcplus4)
  );

  int checks = 0;
  int errors = 0;

  // stimulus knobs for the next cycle
  logic t_rst, t_fe, t_brv, t_ready, t_auto, t_force;
  logic [31:0] t_bra;

  // reference model
  bit          m_known = 1'b0;
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_pcq[$];
  int          m_drop = 0;
  logic [31:0] m_bpc[$];
  logic [31:0] m_bins[$];
  logic [31:0] cache_q[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic fe, input logic br, input logic [31:0] ba,
                       input logic rdy, input logic au, input logic fo);
    t_rst = r; t_fe = fe; t_brv = br; t_bra = ba; t_ready = rdy; t_auto = au; t_force = fo;
  endtask

  task automatic step_cycle();
    int          outst;
    logic        e_req, e_valid, resp;
    logic [31:0] e_instr, e_pc, e_pc4;
    @(negedge clk);
    rst = t_rst; i_fetch_en = t_fe; i_br_valid = t_brv; i_br_addr = t_bra;
    i_icache_ready = t_ready;
    if (t_auto && cache_q.size() > 0) begin
      i_icache_rvalid = 1'b1; i_icache_rdata = memf(cache_q[0]);
    end else if (t_force && cache_q.size() == 0) begin
      i_icache_rvalid = 1'b1; i_icache_rdata = $urandom;
    end else begin
      i_icache_rvalid = 1'b0; i_icache_rdata = $urandom;
    end
    #1;
    outst   = m_pcq.size() + m_drop;
    e_req   = !t_rst && t_fe && !t_brv && (outst + m_bins.size() < DEPTH);
    e_valid = !t_rst && m_bins.size() > 0;
    e_instr = e_valid ? m_bins[0] : 32'h0;
    e_pc    = e_valid ? m_bpc[0] : 32'h0;
    e_pc4   = e_valid ? m_bpc[0] + 32'd4 : 32'h0;
    chk("req", {31'h0, o_icache_req}, {31'h0, e_req});
    if (m_known) chk("addr", o_icache_addr, m_pc);
    chk("valid", {31'h0, o_instr_valid}, {31'h0, e_valid});
    chk("instr", o_instr, e_instr);
    chk("pc", o_pc, e_pc);
    chk("pcplus4", o_pcplus4, e_pc4);
    // cache side: in-order responses to every accepted request
    if (i_icache_rvalid && cache_q.size() > 0) void'(cache_q.pop_front());
    if (e_req && t_ready) cache_q.push_back(m_pc);
    if (t_rst) cache_q.delete();
    // model update for the coming edge
    resp = i_icache_rvalid && outst > 0;
    if (t_rst) begin
      m_known = 1'b1; m_pc = RST_PC; m_drop = 0;
      m_pcq.delete(); m_bpc.delete(); m_bins.delete();
    end else if (t_brv) begin
      m_drop = outst - (resp ? 1 : 0);
      m_pcq.delete(); m_bpc.delete(); m_bins.delete();
      m_pc = t_bra & 32'hFFFF_FFFC;
    end else begin
      if (e_valid && t_fe) begin
        void'(m_bpc.pop_front()); void'(m_bins.pop_front());
      end
      if (resp) begin
        if (m_drop > 0) m_drop--;
        else begin
          m_bins.push_back(i_icache_rdata);
          m_bpc.push_back(m_pcq.pop_front());
        end
      end
      if (e_req && t_ready) begin
        m_pcq.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    // scenario 1: reset, then streaming fetch with single-cycle response latency
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step_cycle();
    chk("rst_req", {31'h0, o_icache_req}, 32'h0);
    chk("rst_valid", {31'h0, o_instr_valid}, 32'h0);
    chk("rst_instr", o_instr, 32'h0);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_pcplus4", o_pcplus4, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step_cycle();
    chk("s1_addr0", o_icache_addr, 32'h0000_0000);
    chk("s1_req0", {31'h0, o_icache_req}, 32'h1);
    chk("s1_nv0", {31'h0, o_instr_valid}, 32'h0);
    step_cycle();
    chk("s1_addr1", o_icache_addr, 32'h0000_0004);
    chk("s1_nv1", {31'h0, o_instr_valid}, 32'h0);
    step_cycle();
    chk("s1_addr2", o_icache_addr, 32'h0000_0008);
    chk("s1_v", {31'h0, o_instr_valid}, 32'h1);
    chk("s1_pc", o_pc, 32'h0000_0000);
    chk("s1_pc4", o_pcplus4, 32'h0000_0004);

    // scenario 2: fetch disabled holds the head, re-enable pops in order
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step_cycle();
      chk("s2_noreq", {31'h0, o_icache_req}, 32'h0);
      chk("s2_hold", o_pc, 32'h0000_0004);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step_cycle();
    chk("s2_pop0", o_pc, 32'h0000_0004);
    step_cycle();
    chk("s2_pop1", o_pc, 32'h0000_0008);

    // scenario 3: redirect with two requests outstanding
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step_cycle();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step_cycle();
    step_cycle();
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0103, 1'b1, 1'b0, 1'b0);
    step_cycle();
    chk("s3_brreq", {31'h0, o_icache_req}, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step_cycle();
    chk("s3_addr", o_icache_addr, 32'h0000_0100);
    chk("s3_nv0", {31'h0, o_instr_valid}, 32'h0);
    step_cycle();
    chk("s3_nv1", {31'h0, o_instr_valid}, 32'h0);
    step_cycle();
    chk("s3_nv2", {31'h0, o_instr_valid}, 32'h0);
    step_cycle();
    chk("s3_v", {31'h0, o_instr_valid}, 32'h1);
    chk("s3_pc", o_pc, 32'h0000_0100);
    chk("s3_instr", o_instr, memf(32'h0000_0100));

    // scenario 4: cache not ready keeps the address stable
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step_cycle();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step_cycle();
      chk("s4_req", {31'h0, o_icache_req}, 32'h1);
      chk("s4_addr", o_icache_addr, RST_PC);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step_cycle();
    step_cycle();
    chk("s4_adv", o_icache_addr, RST_PC + 32'd4);

    // scenario 5: PC wrap at the top of the address space
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step_cycle();
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    step_cycle();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step_cycle();
    chk("s5_top", o_icache_addr, 32'hFFFF_FFFC);
    step_cycle();
    chk("s5_wrap", o_icache_addr, 32'h0000_0000);
    step_cycle();
    chk("s5_pc", o_pc, 32'hFFFF_FFFC);
    chk("s5_pc4", o_pcplus4, 32'h0000_0000);

    // scenario 6: reset with a request in flight, then a late response
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step_cycle();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step_cycle();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step_cycle();
    chk("s6_rstreq", {31'h0, o_icache_req}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    step_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step_cycle();
    chk("s6_nv", {31'h0, o_instr_valid}, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step_cycle();
    chk("s6_req", {31'h0, o_icache_req}, 32'h1);
    chk("s6_addr", o_icache_addr, RST_PC);

    // random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
            $urandom_range(0, 31) == 0);
      step_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
